// File: rtl/dispatch_pkg.sv
// Shared types and defaults for the dispatch router.
// robIdx values are zero-extended to ROB_W_MAX bits for comparison.
package dispatch_pkg;

  localparam int NUM_OUT_DEF = 3;
  localparam int FU_W_DEF    = 4;
  localparam int ROB_W_DEF   = 5;
  localparam int ROB_W_MAX   = 16;

  // Listed output 0 first: out0 = fuType 6, out1 = 4/5/7, out2 = 0..3
  localparam logic [NUM_OUT_DEF*(2**FU_W_DEF)-1:0] FU_MASK_DEF =
    {16'h0040, 16'h00B0, 16'h000F};

  typedef struct packed {
    logic                 flag;
    logic [ROB_W_MAX-1:0] value;
  } robIdx_t;

  function automatic logic isAfter(robIdx_t a, robIdx_t b);
    return (a.flag ^ b.flag) ^ (a.value > b.value);
  endfunction

endpackage

// File: rtl/dispatch_router_if.sv
// Uop input, redirect and per-output issue-queue signals of the router.
// master drives uops and out_ready; slave is the router itself.
interface dispatch_router_if
  import dispatch_pkg::*;
#(
  parameter int NUM_OUT = NUM_OUT_DEF,
  parameter int UOP_W   = 96,
  parameter int FU_W    = FU_W_DEF,
  parameter int ROB_W   = ROB_W_DEF,
  parameter int DEPTH   = 2
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [FU_W-1:0]  in_fuType;
  logic             in_robFlag;
  logic [ROB_W-1:0] in_robValue;
  logic [UOP_W-1:0] in_payload;

  logic             redirect_valid;
  logic             redirect_robFlag;
  logic [ROB_W-1:0] redirect_robValue;

  logic [NUM_OUT-1:0] out_valid;
  logic [NUM_OUT-1:0] out_ready;
  logic [FU_W-1:0]    out_fuType   [NUM_OUT];
  logic [NUM_OUT-1:0] out_robFlag;
  logic [ROB_W-1:0]   out_robValue [NUM_OUT];
  logic [UOP_W-1:0]   out_payload  [NUM_OUT];

  logic             err_nomatch;
  logic [OCC_W-1:0] occupancy [NUM_OUT];

  modport master (
    output in_valid, in_fuType, in_robFlag,
    output in_robValue, in_payload,
    output redirect_valid, redirect_robFlag,
    output redirect_robValue, out_ready,
    input  in_ready, out_valid, out_fuType,
    input  out_robFlag, out_robValue, out_payload,
    input  err_nomatch, occupancy
  );

  modport slave (
    input  in_valid, in_fuType, in_robFlag,
    input  in_robValue, in_payload,
    input  redirect_valid, redirect_robFlag,
    input  redirect_robValue, out_ready,
    output in_ready, out_valid, out_fuType,
    output out_robFlag, out_robValue, out_payload,
    output err_nomatch, occupancy
  );

endinterface

// File: rtl/dispatch_fifo.sv
// In-order issue buffer with wrap-around pointers; a redirect drops
// younger entries and packs survivors back toward the head.
module dispatch_fifo
  import dispatch_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 100,
  parameter int ROB_W  = ROB_W_DEF,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pushValid,
  input  logic [ROB_W:0]    pushRob,
  input  logic [DATA_W-1:0] pushData,
  input  logic              popReady,
  input  logic              flushValid,
  input  robIdx_t           flushRob,
  output logic              headValid,
  output logic [ROB_W:0]    headRob,
  output logic [DATA_W-1:0] headData,
  output logic              full,
  output logic [OCC_W-1:0]  occupancy
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] dataMem [DEPTH];
  logic [ROB_W:0]    robMem  [DEPTH];
  logic [AW-1:0]     rdPtr;
  logic [AW-1:0]     wrPtr;
  logic [OCC_W-1:0]  count;
  logic              push;
  logic              pop;

  logic [DATA_W-1:0] keepData [DEPTH];
  logic [ROB_W:0]    keepRob  [DEPTH];
  logic [OCC_W-1:0]  keepCnt;
  logic [AW-1:0]     slot;
  robIdx_t           entry;

  assign full      = count == OCC_W'(DEPTH);
  assign headValid = count != '0;
  assign push      = pushValid && !full && !flushValid;
  assign pop       = headValid && popReady;
  assign headData  = dataMem[rdPtr];
  assign headRob   = robMem[rdPtr];
  assign occupancy = count;

  // A popped head is removed here too, so the pack skips it
  always_comb begin
    keepCnt = '0;
    slot    = '0;
    entry   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      keepData[k] = '0;
      keepRob[k]  = '0;
    end
    for (int k = 0; k < DEPTH; k++) begin
      slot  = rdPtr + AW'(k);
      entry = {robMem[slot][ROB_W],
               ROB_W_MAX'(robMem[slot][ROB_W-1:0])};
      if (OCC_W'(k) < count && !(k == 0 && pop) &&
          !isAfter(entry, flushRob)) begin
        keepData[keepCnt[AW-1:0]] = dataMem[slot];
        keepRob[keepCnt[AW-1:0]]  = robMem[slot];
        keepCnt = keepCnt + OCC_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        dataMem[k] <= '0;
        robMem[k]  <= '0;
      end
    end else if (flushValid) begin
      for (int k = 0; k < DEPTH; k++) begin
        dataMem[rdPtr + AW'(k)] <= keepData[k];
        robMem[rdPtr + AW'(k)]  <= keepRob[k];
      end
      wrPtr <= rdPtr + keepCnt[AW-1:0];
      count <= keepCnt;
    end else begin
      if (push) begin
        dataMem[wrPtr] <= pushData;
        robMem[wrPtr]  <= pushRob;
        wrPtr          <= wrPtr + AW'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + OCC_W'(1);
      end else if (pop && !push) begin
        count <= count - OCC_W'(1);
      end
    end
  end

endmodule

// File: rtl/dispatch_router.sv
// Routes each uop by fuType to one of NUM_OUT issue buffers,
// round-robin among eligible outputs, with redirect flush.
module dispatch_router
  import dispatch_pkg::*;
#(
  parameter int NUM_OUT = NUM_OUT_DEF,
  parameter int UOP_W   = 96,
  parameter int FU_W    = FU_W_DEF,
  parameter int ROB_W   = ROB_W_DEF,
  parameter logic [NUM_OUT*(2**FU_W)-1:0] FU_MASK = FU_MASK_DEF,
  parameter int DEPTH   = 2
) (
  input logic        clock,
  input logic        reset,
  dispatch_router_if.slave bus
);

  localparam int MW     = 2 ** FU_W;
  localparam int PW     = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam int SW     = PW + 1;
  localparam int DATA_W = FU_W + UOP_W;
  localparam int OCC_W  = $clog2(DEPTH + 1);

  logic [NUM_OUT-1:0] matchVec;
  logic [NUM_OUT-1:0] candVec;
  logic [NUM_OUT-1:0] fullVec;
  logic [NUM_OUT-1:0] grantVec;
  logic [NUM_OUT-1:0] headValid;
  logic [MW-1:0]      maskRow;
  logic [PW-1:0]      rrPtr;
  logic [PW-1:0]      grantIdx;
  logic [PW-1:0]      idx;
  logic [SW-1:0]      sum;
  logic               found;
  logic               inReady;
  logic               accept;
  logic               route;
  logic               drop;
  logic               errQ;
  robIdx_t            flushRob;

  logic [ROB_W:0]    headRob  [NUM_OUT];
  logic [DATA_W-1:0] headData [NUM_OUT];
  logic [OCC_W-1:0]  occ      [NUM_OUT];

  assign flushRob = {bus.redirect_robFlag,
                     ROB_W_MAX'(bus.redirect_robValue)};

  always_comb begin
    maskRow  = '0;
    matchVec = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      maskRow     = FU_MASK[(NUM_OUT-1-i)*MW +: MW];
      matchVec[i] = maskRow[bus.in_fuType];
    end
  end

  assign candVec = matchVec & ~fullVec;

  // Fullness is sampled before this cycle's pop: no ready-to-ready path
  assign inReady = reset && !bus.redirect_valid &&
                   ((|candVec) || !(|matchVec));
  assign accept  = bus.in_valid && inReady;
  assign route   = accept && (|candVec);
  assign drop    = accept && !(|matchVec);

  always_comb begin
    grantVec = '0;
    grantIdx = '0;
    found    = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      sum = {1'b0, rrPtr} + SW'(k);
      if (sum >= SW'(NUM_OUT)) begin
        sum = sum - SW'(NUM_OUT);
      end
      idx = sum[PW-1:0];
      if (!found && candVec[idx]) begin
        found    = 1'b1;
        grantIdx = idx;
      end
    end
    if (route) begin
      grantVec[grantIdx] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rrPtr <= '0;
      errQ  <= 1'b0;
    end else begin
      errQ <= drop;
      if (route) begin
        rrPtr <= (grantIdx == PW'(NUM_OUT - 1)) ?
                 '0 : grantIdx + PW'(1);
      end
    end
  end

  assign bus.in_ready    = inReady;
  assign bus.err_nomatch = errQ;

  for (genvar g = 0; g < NUM_OUT; g++) begin : gOut
    dispatch_fifo #(
      .DEPTH (DEPTH),
      .DATA_W(DATA_W),
      .ROB_W (ROB_W)
    ) uFifo (
      .clock     (clock),
      .reset     (reset),
      .pushValid (grantVec[g]),
      .pushRob   ({bus.in_robFlag, bus.in_robValue}),
      .pushData  ({bus.in_fuType, bus.in_payload}),
      .popReady  (bus.out_ready[g]),
      .flushValid(bus.redirect_valid),
      .flushRob  (flushRob),
      .headValid (headValid[g]),
      .headRob   (headRob[g]),
      .headData  (headData[g]),
      .full      (fullVec[g]),
      .occupancy (occ[g])
    );

    assign bus.out_valid[g]    = headValid[g];
    assign bus.out_fuType[g]   = headData[g][DATA_W-1 -: FU_W];
    assign bus.out_payload[g]  = headData[g][UOP_W-1:0];
    assign bus.out_robFlag[g]  = headRob[g][ROB_W];
    assign bus.out_robValue[g] = headRob[g][ROB_W-1:0];
    assign bus.occupancy[g]    = occ[g];
  end

endmodule

// File: tb/tb_dispatch_router.sv
// Directed bench: default-mask router u0 (DEPTH 2) and a shared-bit-0
// mask router u1 (DEPTH 4) on one clock and reset.
module tb_dispatch_router;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   nChecks = 0;
  int   nFails  = 0;

  always #5 clock = ~clock;

  dispatch_router_if #(
    .NUM_OUT(3), .UOP_W(96), .FU_W(4), .ROB_W(5), .DEPTH(2)
  ) b0 ();

  dispatch_router_if #(
    .NUM_OUT(3), .UOP_W(96), .FU_W(4), .ROB_W(5), .DEPTH(4)
  ) b1 ();

  dispatch_router #(
    .NUM_OUT(3), .UOP_W(96), .FU_W(4), .ROB_W(5),
    .FU_MASK({16'h0040, 16'h00B0, 16'h000F}),
    .DEPTH(2)
  ) u0 (
    .clock(clock),
    .reset(reset),
    .bus  (b0.slave)
  );

  dispatch_router #(
    .NUM_OUT(3), .UOP_W(96), .FU_W(4), .ROB_W(5),
    .FU_MASK({16'h0040, 16'h00B1, 16'h000F}),
    .DEPTH(4)
  ) u1 (
    .clock(clock),
    .reset(reset),
    .bus  (b1.slave)
  );

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [3:0] fu,
                        input logic f, input logic [4:0] rv,
                        input logic [95:0] p);
    b0.in_valid    = v;
    b0.in_fuType   = fu;
    b0.in_robFlag  = f;
    b0.in_robValue = rv;
    b0.in_payload  = p;
  endtask

  task automatic drive1(input logic v, input logic [3:0] fu,
                        input logic f, input logic [4:0] rv,
                        input logic [95:0] p);
    b1.in_valid    = v;
    b1.in_fuType   = fu;
    b1.in_robFlag  = f;
    b1.in_robValue = rv;
    b1.in_payload  = p;
  endtask

  task automatic redir1(input logic v, input logic f,
                        input logic [4:0] rv);
    b1.redirect_valid    = v;
    b1.redirect_robFlag  = f;
    b1.redirect_robValue = rv;
  endtask

  logic [95:0] p0 = 96'hDEADBEEF_CAFEF00D_12345678;
  logic [2:0]  rrExp [4] = '{3'b100, 3'b010, 3'b100, 3'b010};
  int          rrOut [4] = '{2, 1, 2, 1};

  initial begin
    drive0(0, 0, 0, 0, 0);
    drive1(0, 0, 0, 0, 0);
    b0.redirect_valid    = 0;
    b0.redirect_robFlag  = 0;
    b0.redirect_robValue = 0;
    redir1(0, 0, 0);
    b0.out_ready = 3'b000;
    b1.out_ready = 3'b111;

    // reset state
    #12;
    check("rst_valid", b0.out_valid, 3'b000);
    check("rst_occ0", b0.occupancy[0], 0);
    check("rst_err", b0.err_nomatch, 0);
    drive0(1, 6, 0, 1, p0);
    #1;
    check("rst_inready", b0.in_ready, 0);

    // single route, accepted on first edge after release
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("route_inready", b0.in_ready, 1);
    step();
    drive0(0, 0, 0, 0, 0);
    check("route_valid", b0.out_valid, 3'b001);
    check("route_payload", b0.out_payload[0], p0);
    check("route_fu", b0.out_fuType[0], 6);
    check("route_rob", b0.out_robValue[0], 1);
    check("route_occ", b0.occupancy[0], 1);
    step();
    check("route_hold", b0.out_payload[0], p0);
    b0.out_ready = 3'b111;
    step();
    check("route_drain", b0.out_valid, 3'b000);

    // single-match stream to out 1, in order
    b0.out_ready = 3'b010;
    for (int k = 0; k < 4; k++) begin
      drive0(1, 4, 0, 5'(k), 96'(100 + k));
      step();
      check("stream_valid", b0.out_valid, 3'b010);
      check("stream_payload", b0.out_payload[1], 100 + k);
    end
    drive0(0, 0, 0, 0, 0);
    step();
    check("stream_empty", b0.out_valid, 3'b000);

    // round robin between outs 1 and 2 after a grant to out 1
    drive1(1, 4, 0, 0, 200);
    step();
    check("rr_first", b1.out_valid, 3'b010);
    for (int k = 0; k < 4; k++) begin
      drive1(1, 0, 0, 5'(k + 1), 96'(210 + k));
      step();
      check("rr_valid", b1.out_valid, rrExp[k]);
      check("rr_payload", b1.out_payload[rrOut[k]], 210 + k);
    end
    drive1(0, 0, 0, 0, 0);
    step();
    check("rr_empty", b1.out_valid, 3'b000);

    // backpressure on out 2
    b0.out_ready = 3'b011;
    drive0(1, 1, 0, 0, 300);
    #1;
    check("bp_rdy0", b0.in_ready, 1);
    step();
    drive0(1, 1, 0, 1, 301);
    #1;
    check("bp_rdy1", b0.in_ready, 1);
    step();
    drive0(1, 1, 0, 2, 302);
    #1;
    check("bp_full_rdy", b0.in_ready, 0);
    check("bp_occ_full", b0.occupancy[2], 2);
    step();
    check("bp_occ_hold", b0.occupancy[2], 2);
    check("bp_head_hold", b0.out_payload[2], 300);
    b0.out_ready = 3'b111;
    #1;
    check("bp_no_comb", b0.in_ready, 0);
    step();
    check("bp_drain1", b0.out_payload[2], 301);
    check("bp_rdy_again", b0.in_ready, 1);
    step();
    drive0(0, 0, 0, 0, 0);
    check("bp_third", b0.out_payload[2], 302);
    check("bp_occ1", b0.occupancy[2], 1);
    step();
    check("bp_empty", b0.out_valid, 3'b000);

    // flush keeps only entries not after the redirect
    b1.out_ready = 3'b000;
    drive1(1, 1, 0, 3, 400);
    step();
    drive1(1, 1, 0, 5, 401);
    step();
    drive1(1, 1, 0, 7, 402);
    step();
    drive1(0, 0, 0, 0, 0);
    check("fl_occ3", b1.occupancy[2], 3);
    redir1(1, 0, 4);
    #1;
    check("fl_inready", b1.in_ready, 0);
    step();
    redir1(0, 0, 0);
    check("fl_occ", b1.occupancy[2], 1);
    check("fl_rob", b1.out_robValue[2], 3);
    check("fl_payload", b1.out_payload[2], 400);
    check("fl_valid", b1.out_valid, 3'b100);
    b1.out_ready = 3'b100;
    step();
    b1.out_ready = 3'b000;
    check("fl_drain", b1.out_valid, 3'b000);

    // wrapped flag: (1,1) is after (0,30); survivor packs to head
    drive1(1, 1, 1, 1, 500);
    step();
    drive1(1, 1, 0, 2, 501);
    step();
    drive1(0, 0, 0, 0, 0);
    check("wr_head_flag", b1.out_robFlag[2], 1);
    redir1(1, 0, 30);
    step();
    redir1(0, 0, 0);
    check("wr_occ", b1.occupancy[2], 1);
    check("wr_flag", b1.out_robFlag[2], 0);
    check("wr_rob", b1.out_robValue[2], 2);
    check("wr_payload", b1.out_payload[2], 501);

    // unroutable uop is dropped with a one-cycle error
    drive0(1, 15, 0, 0, 600);
    #1;
    check("nm_inready", b0.in_ready, 1);
    step();
    drive0(0, 0, 0, 0, 0);
    check("nm_err", b0.err_nomatch, 1);
    check("nm_novalid", b0.out_valid, 3'b000);
    step();
    check("nm_err_off", b0.err_nomatch, 0);

    // asynchronous reset with two entries buffered
    b0.out_ready = 3'b000;
    drive0(1, 6, 0, 8, 700);
    step();
    drive0(1, 6, 0, 9, 701);
    step();
    drive0(0, 0, 0, 0, 0);
    check("ar_occ2", b0.occupancy[0], 2);
    #2;
    reset = 1'b0;
    #1;
    check("ar_valid", b0.out_valid, 3'b000);
    check("ar_occ", b0.occupancy[0], 0);
    check("ar_inready", b0.in_ready, 0);
    @(negedge clock);
    reset = 1'b1;
    step();
    check("ar_after", b0.out_valid, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
